// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and state encoding for the display arbiter
package display_pkg;

  localparam int NREQ  = 4;
  localparam int VAL_W = 16;
  localparam int PT_W  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner search starting after the last grant
module rr_pick
  import display_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  input  logic            exclude_valid,
  input  logic [1:0]      exclude_idx,
  output logic            found,
  output logic [1:0]      idx
);

  logic [1:0] cand;

  // Walk last+1, last+2, last+3, last and keep the first requesting, non-excluded index.
  always_comb begin
    found = 1'b0;
    idx   = last;
    cand  = last;
    for (int k = 1; k <= NREQ; k++) begin
      cand = last + 2'(k);
      if (!found && req[cand] && !(exclude_valid && (cand == exclude_idx))) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - round-robin display sharing with minimum dwell per grant
module display_arbiter
  import display_pkg::*;
#(
  parameter int DWELL   = 5000000,
  parameter int DWELL_W = 23
) (
  input  logic                   clk5,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*VAL_W-1:0]  req_val,
  input  logic [NREQ*PT_W-1:0]   req_point,
  output logic [NREQ-1:0]        gnt,
  output logic [VAL_W-1:0]       disp_val,
  output logic [PT_W-1:0]        disp_point,
  output logic                   busy
);

  localparam logic [DWELL_W-1:0] CNT_MAX = DWELL_W'(DWELL - 1);
  localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

  state_t               state, state_nxt;
  logic [1:0]           last, last_nxt;
  logic [DWELL_W-1:0]   cnt, cnt_nxt;
  logic [NREQ-1:0]      gnt_nxt;
  logic                 load;
  logic [1:0]           sel;
  logic                 pick_found;
  logic [1:0]           pick_idx;
  logic [VAL_W-1:0]     vals [NREQ];
  logic [PT_W-1:0]      pts  [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign vals[i] = req_val[i*VAL_W +: VAL_W];
    assign pts[i]  = req_point[i*PT_W +: PT_W];
  end

  // While showing, the holder is excluded so the search only finds other contenders;
  // the holder is always 'last', so the dwell-expiry switch can never re-pick it.
  rr_pick u_rr_pick (
    .req           (req),
    .last          (last),
    .exclude_valid (state == ST_SHOW),
    .exclude_idx   (last),
    .found         (pick_found),
    .idx           (pick_idx)
  );

  // Next-state, dwell counter and data-source selection.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    gnt_nxt   = gnt;
    load      = 1'b0;
    sel       = last;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_nxt = ST_SHOW;
          last_nxt  = pick_idx;
          cnt_nxt   = '0;
          gnt_nxt   = 4'b0001 << pick_idx;
          sel       = pick_idx;
          load      = 1'b1;
        end
      end
      ST_SHOW: begin
        if (!req[last] || ((cnt == CNT_MAX) && pick_found)) begin
          if (pick_found) begin
            last_nxt = pick_idx;
            cnt_nxt  = '0;
            gnt_nxt  = 4'b0001 << pick_idx;
            sel      = pick_idx;
            load     = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
            gnt_nxt   = '0;
          end
        end else begin
          load = 1'b1;
          if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // State, grant bookkeeping and display registers; going idle leaves the display untouched.
  always_ff @(posedge clk5) begin
    if (reset) begin
      state      <= ST_IDLE;
      last       <= 2'd3;
      cnt        <= '0;
      gnt        <= '0;
      busy       <= 1'b0;
      disp_val   <= '0;
      disp_point <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
      gnt   <= gnt_nxt;
      busy  <= |gnt_nxt;
      if (load) begin
        disp_val   <= vals[sel];
        disp_point <= pts[sel];
      end
    end
  end

endmodule
